// File: rtl/gol_bank_rotator.sv
// gol_bank_rotator: rotates Game-of-Life generation banks across mirrored RAM pairs (A=evolver, B=display).
// Optional live-cell counter is compiled in when GOL_BANK_POPCNT_EN is defined.
module gol_bank_rotator #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 2,
    parameter int GEN_W     = 16,
    localparam int IDX_W    = $clog2(NUM_BANKS),
    localparam int POP_W    = ADDR_W + $clog2(DATA_W) + 1,
    localparam int NPHYS    = 2 * NUM_BANKS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mode_load_i,
    input  logic [ADDR_W-1:0]         ld_addr_i,
    input  logic [DATA_W-1:0]         ld_wdata_i,
    input  logic                      ld_wren_i,
    input  logic [ADDR_W-1:0]         ev_raddr_i,
    input  logic                      ev_rden_i,
    output logic [DATA_W-1:0]         ev_rdata_o,
    input  logic [ADDR_W-1:0]         ev_waddr_i,
    input  logic [DATA_W-1:0]         ev_wdata_i,
    input  logic                      ev_wren_i,
    input  logic                      swap_req_i,
    output logic                      swap_ack_o,
    input  logic                      frame_start_i,
    input  logic [ADDR_W-1:0]         disp_addr_i,
    input  logic                      disp_rden_i,
    output logic [DATA_W-1:0]         disp_rdata_o,
    output logic [IDX_W-1:0]          src_idx_o,
    output logic [IDX_W-1:0]          disp_idx_o,
    output logic [GEN_W-1:0]          generation_o,
    output logic [POP_W-1:0]          pop_count_o,
    output logic [NPHYS*ADDR_W-1:0]   bank_addr_o,
    output logic [NPHYS*DATA_W-1:0]   bank_wdata_o,
    output logic [NPHYS-1:0]          bank_wren_o,
    output logic [NPHYS-1:0]          bank_rden_o,
    input  logic [NPHYS*DATA_W-1:0]   bank_q_i
);

    localparam int NSEL = 2 ** IDX_W;
    localparam int QW   = 2 * NSEL * DATA_W;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   src_idx_q;
    logic [IDX_W-1:0]   disp_idx_q;
    logic [IDX_W-1:0]   ev_sel_q;
    logic [IDX_W-1:0]   disp_sel_q;
    logic               ev_vld_q;
    logic               disp_vld_q;
    logic               swap_ack_q;
    logic [GEN_W-1:0]   gen_q;

    logic [IDX_W-1:0]   dst_s;
    logic               accept_s;
    logic               swap_seen_s;
    logic               commit_s;
    logic [NPHYS-1:0]   wren_s;
    logic [QW-1:0]      q_pad_s;
    logic [DATA_W-1:0]  q_a_s [NSEL];
    logic [DATA_W-1:0]  q_b_s [NSEL];

    assign dst_s    = (src_idx_q == IDX_W'(NUM_BANKS - 1)) ? '0 : src_idx_q + IDX_W'(1);
    assign accept_s = frame_start_i || ((NUM_BANKS >= 3) && (disp_idx_q == src_idx_q));
    // The requester still holds swap_req during the ack cycle; that cycle must not re-trigger.
    assign swap_seen_s = swap_req_i && !swap_ack_q && !mode_load_i && (state_q != ST_LOAD);
    assign commit_s    = swap_seen_s && accept_s;

    // Bank rotation FSM with registered control outputs and read-select pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            src_idx_q  <= '0;
            disp_idx_q <= '0;
            ev_sel_q   <= '0;
            disp_sel_q <= '0;
            ev_vld_q   <= 1'b0;
            disp_vld_q <= 1'b0;
            swap_ack_q <= 1'b0;
            gen_q      <= '0;
        end else begin
            swap_ack_q <= 1'b0;
            ev_vld_q   <= ev_rden_i && (state_q != ST_LOAD);
            disp_vld_q <= disp_rden_i && (state_q != ST_LOAD);
            ev_sel_q   <= src_idx_q;
            disp_sel_q <= disp_idx_q;
            if (mode_load_i) begin
                state_q    <= ST_LOAD;
                src_idx_q  <= '0;
                disp_idx_q <= '0;
                gen_q      <= '0;
            end else begin
                case (state_q)
                    ST_LOAD: state_q <= ST_RUN;
                    ST_RUN, ST_PEND: begin
                        if (commit_s) begin
                            state_q    <= ST_RUN;
                            swap_ack_q <= 1'b1;
                            src_idx_q  <= dst_s;
                            gen_q      <= gen_q + GEN_W'(1);
                        end else if (swap_seen_s) begin
                            state_q <= ST_PEND;
                        end else begin
                            state_q <= ST_RUN;
                        end
                        if (frame_start_i) begin
                            disp_idx_q <= commit_s ? dst_s : src_idx_q;
                        end else begin
                            disp_idx_q <= disp_idx_q;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    // Physical RAM routing: loader broadcasts, otherwise dst takes writes on both copies.
    always_comb begin
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_rden_o  = '0;
        wren_s       = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q == ST_LOAD) begin
                for (int c = 0; c < 2; c++) begin
                    bank_addr_o[(2*b+c)*ADDR_W +: ADDR_W]  = ld_addr_i;
                    bank_wdata_o[(2*b+c)*DATA_W +: DATA_W] = ld_wdata_i;
                    wren_s[2*b+c]                          = ld_wren_i;
                end
            end else if (dst_s == IDX_W'(b)) begin
                for (int c = 0; c < 2; c++) begin
                    bank_addr_o[(2*b+c)*ADDR_W +: ADDR_W]  = ev_waddr_i;
                    bank_wdata_o[(2*b+c)*DATA_W +: DATA_W] = ev_wdata_i;
                    wren_s[2*b+c]                          = ev_wren_i;
                end
            end else begin
                bank_addr_o[(2*b)*ADDR_W +: ADDR_W]   = ev_raddr_i;
                bank_rden_o[2*b]                      = ev_rden_i && (src_idx_q == IDX_W'(b));
                bank_addr_o[(2*b+1)*ADDR_W +: ADDR_W] = disp_addr_i;
                bank_rden_o[2*b+1]                    = disp_rden_i && (disp_idx_q == IDX_W'(b));
            end
        end
    end

    assign bank_wren_o = rst_i ? '0 : wren_s;

    // Split RAM read data into per-bank A/B words, padded to a power-of-two table.
    always_comb begin
        q_pad_s = QW'(bank_q_i);
        for (int b = 0; b < NSEL; b++) begin
            q_a_s[b] = q_pad_s[(2*b)*DATA_W +: DATA_W];
            q_b_s[b] = q_pad_s[(2*b+1)*DATA_W +: DATA_W];
        end
    end

    assign ev_rdata_o   = (ev_vld_q && (state_q != ST_LOAD)) ? q_a_s[ev_sel_q] : '0;
    assign disp_rdata_o = (disp_vld_q && (state_q != ST_LOAD)) ? q_b_s[disp_sel_q] : '0;
    assign swap_ack_o   = swap_ack_q;
    assign src_idx_o    = src_idx_q;
    assign disp_idx_o   = disp_idx_q;
    assign generation_o = gen_q;

`ifdef GOL_BANK_POPCNT_EN
    logic [POP_W-1:0] acc_q;
    logic [POP_W-1:0] pop_q;
    logic [POP_W-1:0] acc_sum_s;

    function automatic logic [POP_W-1:0] popcnt(input logic [DATA_W-1:0] w);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + POP_W'(w[i]);
        end
        return n;
    endfunction

    assign acc_sum_s = acc_q + ((ev_wren_i && (state_q != ST_LOAD)) ? popcnt(ev_wdata_i) : '0);

    // Live-cell accumulator; a commit folds in the same-cycle write before latching.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            pop_q <= '0;
        end else if (mode_load_i || (state_q == ST_LOAD)) begin
            acc_q <= '0;
            pop_q <= '0;
        end else if (commit_s) begin
            acc_q <= '0;
            pop_q <= acc_sum_s;
        end else begin
            acc_q <= acc_sum_s;
        end
    end

    assign pop_count_o = pop_q;
`else
    assign pop_count_o = '0;
`endif

endmodule

// File: tb/tb_gol_bank_rotator.sv
// Directed bench for gol_bank_rotator: a 2-bank and a 3-bank instance share stimulus, each with RAM models.
module tb_gol_bank_rotator;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int GW = 16;
    localparam int PW = AW + 5 + 1;
`ifdef GOL_BANK_POPCNT_EN
    localparam logic [PW-1:0] POPX = 12'd5;
`else
    localparam logic [PW-1:0] POPX = 12'd0;
`endif

    logic clk, rst;
    logic mode_load, ld_wren, ev_rden, ev_wren, swap_req, frame_start, disp_rden;
    logic [AW-1:0] ld_addr, ev_raddr, ev_waddr, disp_addr;
    logic [DW-1:0] ld_wdata, ev_wdata;

    logic [DW-1:0] ev_rd2, disp_rd2, ev_rd3, disp_rd3;
    logic ack2, ack3;
    logic src2, disp2;
    logic [1:0] src3, disp3;
    logic [GW-1:0] gen2, gen3;
    logic [PW-1:0] pop2, pop3;
    logic [4*AW-1:0] addr2;
    logic [4*DW-1:0] wd2, q2;
    logic [3:0] wren2, rden2;
    logic [6*AW-1:0] addr3;
    logic [6*DW-1:0] wd3, q3;
    logic [5:0] wren3, rden3;

    logic [DW-1:0] mem2 [4][64];
    logic [DW-1:0] mem3 [6][64];

    int n_checks = 0;
    int n_errors = 0;
    logic ack_seen;

    gol_bank_rotator #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(2), .GEN_W(GW)) u2 (
        .clk_i(clk), .rst_i(rst), .mode_load_i(mode_load),
        .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_wren_i(ld_wren),
        .ev_raddr_i(ev_raddr), .ev_rden_i(ev_rden), .ev_rdata_o(ev_rd2),
        .ev_waddr_i(ev_waddr), .ev_wdata_i(ev_wdata), .ev_wren_i(ev_wren),
        .swap_req_i(swap_req), .swap_ack_o(ack2), .frame_start_i(frame_start),
        .disp_addr_i(disp_addr), .disp_rden_i(disp_rden), .disp_rdata_o(disp_rd2),
        .src_idx_o(src2), .disp_idx_o(disp2), .generation_o(gen2), .pop_count_o(pop2),
        .bank_addr_o(addr2), .bank_wdata_o(wd2), .bank_wren_o(wren2), .bank_rden_o(rden2),
        .bank_q_i(q2)
    );

    gol_bank_rotator #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(3), .GEN_W(GW)) u3 (
        .clk_i(clk), .rst_i(rst), .mode_load_i(mode_load),
        .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_wren_i(ld_wren),
        .ev_raddr_i(ev_raddr), .ev_rden_i(ev_rden), .ev_rdata_o(ev_rd3),
        .ev_waddr_i(ev_waddr), .ev_wdata_i(ev_wdata), .ev_wren_i(ev_wren),
        .swap_req_i(swap_req), .swap_ack_o(ack3), .frame_start_i(frame_start),
        .disp_addr_i(disp_addr), .disp_rden_i(disp_rden), .disp_rdata_o(disp_rd3),
        .src_idx_o(src3), .disp_idx_o(disp3), .generation_o(gen3), .pop_count_o(pop3),
        .bank_addr_o(addr3), .bank_wdata_o(wd3), .bank_wren_o(wren3), .bank_rden_o(rden3),
        .bank_q_i(q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency single-port RAM models
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (wren2[p]) mem2[p][addr2[p*AW +: AW]] <= wd2[p*DW +: DW];
            if (rden2[p]) q2[p*DW +: DW] <= mem2[p][addr2[p*AW +: AW]];
        end
    end

    always @(posedge clk) begin
        for (int p = 0; p < 6; p++) begin
            if (wren3[p]) mem3[p][addr3[p*AW +: AW]] <= wd3[p*DW +: DW];
            if (rden3[p]) q3[p*DW +: DW] <= mem3[p][addr3[p*AW +: AW]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode_load = 1'b0; ld_wren = 1'b0; ev_rden = 1'b0; ev_wren = 1'b0;
        swap_req = 1'b0; frame_start = 1'b0; disp_rden = 1'b0;
        ld_addr = '0; ev_raddr = '0; ev_waddr = '0; disp_addr = '0;
        ld_wdata = '0; ev_wdata = '0; q2 = '0; q3 = '0;
        step();
        check_eq("rst_src2", src2, 0);
        check_eq("rst_disp3", disp3, 0);
        check_eq("rst_gen2", gen2, 0);
        check_eq("rst_ack3", ack3, 0);
        check_eq("rst_pop2", pop2, 0);
        check_eq("rst_wren3", wren3, 0);
        check_eq("rst_evrd2", ev_rd2, 0);
        check_eq("rst_disprd3", disp_rd3, 0);
        rst = 1'b0;

        // load addr 5 with A5 into every RAM
        mode_load = 1'b1;
        step();
        ld_addr = 6'd5; ld_wdata = 32'hA5; ld_wren = 1'b1;
        #1;
        check_eq("load_wren2", wren2, 4'hF);
        check_eq("load_wren3", wren3, 6'h3F);
        step();
        ld_wren = 1'b0; mode_load = 1'b0;
        step();
        disp_addr = 6'd5; disp_rden = 1'b1; ev_raddr = 6'd5; ev_rden = 1'b1;
        step();
        check_eq("post_load_disp2", disp_rd2, 32'hA5);
        check_eq("post_load_disp3", disp_rd3, 32'hA5);
        check_eq("post_load_ev2", ev_rd2, 32'hA5);
        check_eq("post_load_src2", src2, 0);

        // evolver writes to dst=1 while reading the same address from src=0
        disp_rden = 1'b0;
        ev_waddr = 6'd5; ev_wdata = 32'hF; ev_wren = 1'b1;
        #1;
        check_eq("ev_wren3_dst1", wren3, 6'b001100);
        step();
        check_eq("same_addr_rd2", ev_rd2, 32'hA5);
        ev_rden = 1'b0;
        ev_waddr = 6'd7; ev_wdata = 32'h1;
        step();
        ev_waddr = 6'd8; ev_wdata = 32'h0;
        step();
        ev_wren = 1'b0;

        // swap request: 3-bank commits at once, 2-bank waits for frame_start
        swap_req = 1'b1;
        step();
        check_eq("n3_ack", ack3, 1);
        check_eq("n3_src", src3, 1);
        check_eq("n3_disp_hold", disp3, 0);
        check_eq("n3_gen", gen3, 1);
        check_eq("n3_pop", pop3, POPX);
        check_eq("n2_no_ack", ack2, 0);
        check_eq("n2_src_hold", src2, 0);
        ack_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            ack_seen = ack_seen | ack2 | ack3;
        end
        check_eq("no_ack_before_frame", ack_seen, 0);
        frame_start = 1'b1; disp_rden = 1'b1; disp_addr = 6'd5;
        step();
        frame_start = 1'b0; swap_req = 1'b0;
        check_eq("n2_frame_ack", ack2, 1);
        check_eq("n2_src", src2, 1);
        check_eq("n2_disp", disp2, 1);
        check_eq("n2_gen", gen2, 1);
        check_eq("n2_pop", pop2, POPX);
        check_eq("n3_pend_ack", ack3, 1);
        check_eq("n3_src2", src3, 2);
        check_eq("n3_disp2", disp3, 2);
        check_eq("n3_gen2", gen3, 2);
        check_eq("n3_pop_cleared", pop3, 0);
        check_eq("n2_inflight_old_bank", disp_rd2, 32'hA5);
        ev_rden = 1'b1; ev_raddr = 6'd5;
        step();
        check_eq("n2_disp_new_bank", disp_rd2, 32'hF);
        check_eq("n2_ev_new_src", ev_rd2, 32'hF);
        check_eq("n3_disp_bank2", disp_rd3, 32'hA5);
        check_eq("n3_ev_bank2", ev_rd3, 32'hA5);
        ev_rden = 1'b0; disp_rden = 1'b0;

        // src wraps 2->0 on the 3-bank instance, then LOAD aborts pending swaps
        swap_req = 1'b1;
        step();
        check_eq("n3_wrap_src", src3, 0);
        check_eq("n3_wrap_gen", gen3, 3);
        check_eq("n2_pend_no_ack", ack2, 0);
        step();
        step();
        mode_load = 1'b1; disp_rden = 1'b1;
        step();
        check_eq("load_ack2", ack2, 0);
        check_eq("load_ack3", ack3, 0);
        check_eq("load_src2", src2, 0);
        check_eq("load_disp2", disp2, 0);
        check_eq("load_gen2", gen2, 0);
        check_eq("load_gen3", gen3, 0);
        check_eq("load_pop2", pop2, 0);
        check_eq("load_disprd2", disp_rd2, 0);
        swap_req = 1'b0; mode_load = 1'b0; disp_rden = 1'b0;
        step();

        // reset during a write kills RAM write enables immediately
        ev_wren = 1'b1; ev_waddr = 6'd3; ev_wdata = 32'h0;
        #1;
        check_eq("pre_rst_wren2", wren2, 4'b1100);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_wren2", wren2, 0);
        check_eq("rst_mid_wren3", wren3, 0);
        step();
        rst = 1'b0; ev_wren = 1'b0;

        // request withdrawn while pending: no ack on the 2-bank instance
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_eq("withdraw_ack2", ack2, 0);
        check_eq("withdraw_src2", src2, 0);
        check_eq("withdraw_gen2", gen2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
